// File: rtl/mux4_rr_sel_ctrl.sv
// Round-robin owner arbitration for a shared 1-bit 4:1 mux.
// Drives the mux selects, bounds each ownership with a hold timeout and registers the mux output.
module mux4_rr_sel_ctrl #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       mux_e,
    output logic [3:0] gnt,
    output logic       s1,
    output logic       s2,
    output logic       busy,
    output logic       dout,
    output logic       dout_vld,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

    state_t           state;
    logic [1:0]       last;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_nxt;
    logic [1:0]       own;
    logic [1:0]       winner;
    logic             any_req;
    logic             release_own;

    assign own         = {s1, s2};
    assign any_req     = |req;
    assign hold_nxt    = hold_cnt + CNT_W'(1);
    assign release_own = !req[own] || (hold_cnt == HOLD_MAX);

    // Scan last+4 down to last+1 so the nearest set request after last wins;
    // the just-released index (offset 4) ends up with the lowest priority.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        winner = last + 2'd1;
        for (int i = 4; i >= 1; i--) begin
            if (req[last + 2'(i)]) begin
                winner = last + 2'(i);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last     <= 2'd3;
            hold_cnt <= '0;
            gnt      <= 4'b0000;
            s1       <= 1'b0;
            s2       <= 1'b0;
            busy     <= 1'b0;
            dout     <= 1'b0;
            dout_vld <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    dout_vld <= 1'b0;
                    timeout  <= 1'b0;
                    if (any_req) begin
                        state    <= GRANT;
                        gnt      <= 4'b0001 << winner;
                        s1       <= winner[1];
                        s2       <= winner[0];
                        last     <= winner;
                        hold_cnt <= CNT_W'(1);
                        busy     <= 1'b1;
                        timeout  <= (HOLD_MAX == CNT_W'(1));
                    end
                end
                GRANT: begin
                    dout <= mux_e;
                    if (release_own) begin
                        state    <= IDLE;
                        gnt      <= 4'b0000;
                        busy     <= 1'b0;
                        dout_vld <= 1'b0;
                        timeout  <= 1'b0;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_nxt;
                        dout_vld <= 1'b1;
                        // Registered pulse covering the final allowed GRANT cycle.
                        timeout  <= (hold_nxt == HOLD_MAX);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_rr_sel_ctrl.sv
// Directed bench for mux4_rr_sel_ctrl: arbitration order, hold timeout, data path and async reset.
// Includes a behavioural 4:1 mux closing the select/data loop.
module tb_mux4_rr_sel_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       mux_e;
    logic [3:0] gnt;
    logic       s1;
    logic       s2;
    logic       busy;
    logic       dout;
    logic       dout_vld;
    logic       timeout;
    logic [3:0] mux_in;   // {d, c, b, a}

    int total = 0;
    int bad   = 0;

    mux4_rr_sel_ctrl #(.MAX_HOLD(8), .CNT_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .mux_e    (mux_e),
        .gnt      (gnt),
        .s1       (s1),
        .s2       (s2),
        .busy     (busy),
        .dout     (dout),
        .dout_vld (dout_vld),
        .timeout  (timeout)
    );

    assign mux_e = mux_in[{s1, s2}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        req    = 4'b0000;
        mux_in = 4'b1010;   // a=0, b=1, c=0, d=1

        // T1: reset values, single request, release
        do_reset();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_sel", 32'({s1, s2}), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_vld", 32'(dout_vld), 32'h0);
        check("rst_tmo", 32'(timeout), 32'h0);
        req = 4'b0001;
        check("t1_latency", 32'(gnt), 32'h0);
        step();
        check("t1_gnt", 32'(gnt), 32'h1);
        check("t1_sel", 32'({s1, s2}), 32'h0);
        check("t1_busy", 32'(busy), 32'h1);
        check("t1_vld0", 32'(dout_vld), 32'h0);
        req = 4'b0000;
        step();
        check("t1_rel_gnt", 32'(gnt), 32'h0);
        check("t1_rel_busy", 32'(busy), 32'h0);

        // T2: all requesting, rotation 0,1,2,3,0 with 8-cycle ownerships
        do_reset();
        req = 4'b1111;
        begin
            int order [5] = '{0, 1, 2, 3, 0};
            foreach (order[n]) begin
                step();
                for (int k = 1; k <= 8; k++) begin
                    check($sformatf("t2_gnt_o%0d_c%0d", n, k), 32'(gnt), 32'(4'b0001 << order[n]));
                    check($sformatf("t2_tmo_o%0d_c%0d", n, k), 32'(timeout), 32'(k == 8));
                    step();
                end
                check($sformatf("t2_idle_gnt_o%0d", n), 32'(gnt), 32'h0);
                check($sformatf("t2_idle_busy_o%0d", n), 32'(busy), 32'h0);
                check($sformatf("t2_idle_tmo_o%0d", n), 32'(timeout), 32'h0);
                check($sformatf("t2_idle_sel_o%0d", n), 32'({s1, s2}), 32'(order[n]));
            end
        end

        // T3: lone requester times out, idles one cycle, then is re-granted
        do_reset();
        req = 4'b0100;
        step();
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("t3_gnt_c%0d", k), 32'(gnt), 32'h4);
            check($sformatf("t3_tmo_c%0d", k), 32'(timeout), 32'(k == 8));
            step();
        end
        check("t3_idle", 32'(gnt), 32'h0);
        step();
        check("t3_regrant", 32'(gnt), 32'h4);
        check("t3_regrant_tmo", 32'(timeout), 32'h0);

        // T4: data path through the mux
        do_reset();
        req = 4'b0010;
        step();
        check("t4_sel_b", 32'({s1, s2}), 32'h1);
        check("t4_vld_c1", 32'(dout_vld), 32'h0);
        step();
        check("t4_dout_b", 32'(dout), 32'h1);
        check("t4_vld_c2", 32'(dout_vld), 32'h1);
        req = 4'b0000;
        step();
        check("t4_idle_vld", 32'(dout_vld), 32'h0);
        check("t4_idle_dout", 32'(dout), 32'h1);
        check("t4_idle_sel", 32'({s1, s2}), 32'h1);
        req = 4'b0100;
        step();
        check("t4_sel_c", 32'({s1, s2}), 32'h2);
        step();
        check("t4_dout_c", 32'(dout), 32'h0);
        check("t4_vld_c", 32'(dout_vld), 32'h1);
        req = 4'b0000;
        step();

        // T5: non-owner changes ignored; rotation from last=1 picks 3 over 0
        do_reset();
        req = 4'b0010;
        step();
        check("t5_gnt1", 32'(gnt), 32'h2);
        req = 4'b1011;
        step();
        check("t5_hold1", 32'(gnt), 32'h2);
        req = 4'b1001;
        step();
        check("t5_rel", 32'(gnt), 32'h0);
        step();
        check("t5_gnt3", 32'(gnt), 32'h8);
        check("t5_sel3", 32'({s1, s2}), 32'h3);
        req = 4'b0000;
        step();

        // T6: asynchronous reset mid-GRANT, then arbitration from last=3
        do_reset();
        req = 4'b0010;
        step();
        step();
        check("t6_pre_vld", 32'(dout_vld), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_gnt", 32'(gnt), 32'h0);
        check("t6_async_busy", 32'(busy), 32'h0);
        check("t6_async_vld", 32'(dout_vld), 32'h0);
        check("t6_async_sel", 32'({s1, s2}), 32'h0);
        step();
        rst_n = 1'b1;
        req   = 4'b1001;
        step();
        check("t6_gnt0", 32'(gnt), 32'h1);
        req = 4'b0000;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
